glyph_row_renderer: RTL and testbench

- Parametrised next-generation note/glyph plotter for the VGA adapter pixel interface; one pixel write per clock.
- Draws a row of NUM_GLYPHS bitmap glyphs (e.g. sharp, letter, octave) at a base (x,y) with a fixed horizontal pitch.
- Also supports erasing that row and clearing the full screen.
- Sits between the note-to-bitmap lookup and the VGA adapter, under a start/busy/done handshake.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/glyph_scan_counter.sv | 42 ++++
 rtl/glyph_row_renderer.sv | 194 +++++++++++++++++++
 tb/tb_glyph_row_renderer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-plotting blocks: command codes, FSM
// state encoding, default screen geometry and a few named colours.
package vga_pkg;

  localparam logic [1:0] CMD_DRAW   = 2'd0;
  localparam logic [1:0] CMD_ERASE  = 2'd1;
  localparam logic [1:0] CMD_CLRSCR = 2'd2;
  localparam logic [1:0] CMD_NOP    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW   = 3'd1,
    S_ERASE  = 3'd2,
    S_CLRSCR = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  // Bits needed to hold indices 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/glyph_scan_counter.sv
// Nested slot/row/col scan counter (col fastest) with run-time limits and a
// flag marking the final position of the scan; wraps to zero after it.
module glyph_scan_counter #(
  parameter int SLOT_W = 2,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [SLOT_W-1:0] max_slot,
  input  logic [ROW_W-1:0]  max_row,
  input  logic [COL_W-1:0]  max_col,
  output logic [SLOT_W-1:0] slot,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last
);

  assign last = (slot == max_slot) && (row == max_row) && (col == max_col);

  always_ff @(posedge clk) begin
    if (clear) begin
      slot <= '0;
      row  <= '0;
      col  <= '0;
    end else if (en) begin
      if (col == max_col) begin
        col <= '0;
        if (row == max_row) begin
          row <= '0;
          slot <= (slot == max_slot) ? '0 : slot + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/glyph_row_renderer.sv
// Plots a row of bitmap glyphs, erases the row box or clears the screen,
// emitting one registered pixel write per clock under start/busy/done.
module glyph_row_renderer
  import vga_pkg::*;
#(
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int NUM_GLYPHS = 3,
  parameter int PITCH      = 12,
  parameter int SCR_W      = SCR_W_DEF,
  parameter int SCR_H      = SCR_H_DEF,
  parameter int X_W        = 8,
  parameter int Y_W        = 7
) (
  input  logic                                 clk,
  input  logic                                 clear,
  input  logic                                 start,
  input  logic [1:0]                           cmd,
  input  logic [X_W-1:0]                       x,
  input  logic [Y_W-1:0]                       y,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyphs,
  input  logic [NUM_GLYPHS-1:0]                slot_en,
  input  logic                                 opaque,
  input  logic [2:0]                           fg,
  input  logic [2:0]                           bg,
  output logic [X_W-1:0]                       x_out,
  output logic [Y_W-1:0]                       y_out,
  output logic                                 writeEn,
  output logic [2:0]                           colour,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           state_dbg
);

  localparam int GBITS  = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int SLOT_W = cnt_w(NUM_GLYPHS);
  localparam int ROW_W  = cnt_w((GLYPH_H > SCR_H) ? GLYPH_H : SCR_H);
  localparam int COL_W  = cnt_w((GLYPH_W > SCR_W) ? GLYPH_W : SCR_W);
  localparam int GIDX_W = cnt_w(GBITS);

  state_t state_q, state_d;
  logic   cnt_en, last_q, scan_last, idle;

  logic [1:0]            cmd_q, src_cmd;
  logic [X_W-1:0]        x_q, src_x;
  logic [Y_W-1:0]        y_q, src_y;
  logic [GBITS-1:0]      glyphs_q, src_glyphs;
  logic [NUM_GLYPHS-1:0] slot_en_q, src_slot_en;
  logic                  opaque_q, src_opaque;
  logic [2:0]            fg_q, bg_q, src_fg, src_bg;

  logic [SLOT_W-1:0] slot, max_slot;
  logic [ROW_W-1:0]  row, max_row;
  logic [COL_W-1:0]  col, max_col;
  logic              clr_mode;

  int                px, py;
  logic              in_scr, gbit, pix_we;
  logic [2:0]        pix_col;
  logic [GIDX_W-1:0] gidx;

  // Pixel 0 is produced on the accepting edge, so while idle the scan reads
  // the live inputs; afterwards it reads the latched copy.
  assign idle        = (state_q == S_IDLE);
  assign src_cmd     = idle ? cmd     : cmd_q;
  assign src_x       = idle ? x       : x_q;
  assign src_y       = idle ? y       : y_q;
  assign src_glyphs  = idle ? glyphs  : glyphs_q;
  assign src_slot_en = idle ? slot_en : slot_en_q;
  assign src_opaque  = idle ? opaque  : opaque_q;
  assign src_fg      = idle ? fg      : fg_q;
  assign src_bg      = idle ? bg      : bg_q;
  assign state_dbg   = state_q;

  assign clr_mode = (src_cmd == CMD_CLRSCR);
  assign max_slot = clr_mode ? '0 : SLOT_W'(NUM_GLYPHS - 1);
  assign max_row  = clr_mode ? ROW_W'(SCR_H - 1) : ROW_W'(GLYPH_H - 1);
  assign max_col  = clr_mode ? COL_W'(SCR_W - 1) : COL_W'(GLYPH_W - 1);

  glyph_scan_counter #(
    .SLOT_W(SLOT_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_scan (
    .clk     (clk),
    .clear   (clear),
    .en      (cnt_en),
    .max_slot(max_slot),
    .max_row (max_row),
    .max_col (max_col),
    .slot    (slot),
    .row     (row),
    .col     (col),
    .last    (scan_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_DRAW:   state_d = S_DRAW;
            CMD_ERASE:  state_d = S_ERASE;
            CMD_CLRSCR: state_d = S_CLRSCR;
            default:    state_d = S_FIN;
          endcase
          cnt_en = (cmd != CMD_NOP);
        end
      end
      S_DRAW, S_ERASE, S_CLRSCR: begin
        if (last_q) state_d = S_FIN;
        else        cnt_en  = 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coordinates are formed wide so off-screen pixels clip instead of wrapping.
  always_comb begin
    px      = 0;
    py      = 0;
    in_scr  = 1'b0;
    pix_we  = 1'b0;
    pix_col = src_bg;
    gidx    = GIDX_W'((NUM_GLYPHS - int'(slot)) * GLYPH_W * GLYPH_H - 1
                      - (int'(row) * GLYPH_W + int'(col)));
    gbit    = src_glyphs[gidx];
    case (src_cmd)
      CMD_CLRSCR: begin
        px     = int'(col);
        py     = int'(row);
        pix_we = 1'b1;
      end
      CMD_DRAW, CMD_ERASE: begin
        px     = int'(src_x) + int'(slot) * PITCH + int'(col);
        py     = int'(src_y) + int'(row);
        in_scr = (px < SCR_W) && (py < SCR_H);
        if (src_cmd == CMD_ERASE) begin
          pix_we = in_scr;
        end else begin
          pix_we  = in_scr && src_slot_en[slot] && (gbit || src_opaque);
          pix_col = gbit ? src_fg : src_bg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      cmd_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      glyphs_q  <= '0;
      slot_en_q <= '0;
      opaque_q  <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      colour    <= '0;
      writeEn   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= cnt_en && scan_last;
      busy    <= (state_d == S_DRAW) || (state_d == S_ERASE) || (state_d == S_CLRSCR);
      done    <= (state_d == S_FIN);
      writeEn <= cnt_en && pix_we;
      if (cnt_en && pix_we) begin
        x_out  <= X_W'(px);
        y_out  <= Y_W'(py);
        colour <= pix_col;
      end
      if (idle && start) begin
        cmd_q     <= cmd;
        x_q       <= x;
        y_q       <= y;
        glyphs_q  <= glyphs;
        slot_en_q <= slot_en;
        opaque_q  <= opaque;
        fg_q      <= fg;
        bg_q      <= bg;
      end
    end
  end

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Directed bench for glyph_row_renderer: table of commands with hand-derived
// write counts, extents and timing, plus reset/abort and ignored-start cases.
module tb_glyph_row_renderer;

  localparam int GB = 432;

  logic          clk = 1'b0;
  logic          clear, start, opaque, writeEn, busy, done;
  logic [1:0]    cmd;
  logic [7:0]    x, x_out;
  logic [6:0]    y, y_out;
  logic [GB-1:0] glyphs;
  logic [2:0]    slot_en, fg, bg, colour, state_dbg;

  glyph_row_renderer dut (
    .clk(clk), .clear(clear), .start(start), .cmd(cmd), .x(x), .y(y),
    .glyphs(glyphs), .slot_en(slot_en), .opaque(opaque), .fg(fg), .bg(bg),
    .x_out(x_out), .y_out(y_out), .writeEn(writeEn), .colour(colour),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    cmd;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [GB-1:0] glyphs;
    logic [2:0]    slot_en;
    logic          opaque;
    logic [2:0]    fg, bg;
    int            inj_at;
    logic          fin_start;
    int            rx_lo, rx_hi;
    logic          raster;
    int            exp_writes, exp_busy;
    int            exp_fx, exp_fy;
    logic [2:0]    exp_fc;
    int            exp_lx, exp_ly;
    logic [2:0]    exp_lc;
    int            exp_minx, exp_maxx;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0, n_fail = 0;

  int         r_writes, r_busy, r_done, r_done_bad, r_inrange, r_minx, r_maxx;
  int         r_order_err, r_fx, r_fy, r_lx, r_ly, r_post_busy;
  logic [2:0] r_fc, r_lc;
  logic       r_timeout;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic seen;
    int   tail;
    @(negedge clk);
    cmd = v.cmd; x = v.x; y = v.y; glyphs = v.glyphs; slot_en = v.slot_en;
    opaque = v.opaque; fg = v.fg; bg = v.bg; start = 1'b1;
    @(negedge clk);
    // Inputs are disturbed after acceptance; the command must not notice.
    x = ~v.x; y = ~v.y; glyphs = ~v.glyphs; fg = ~v.fg; bg = ~v.bg;
    slot_en = ~v.slot_en; opaque = ~v.opaque;
    r_writes = 0; r_busy = 0; r_done = 0; r_done_bad = 0; r_inrange = 0;
    r_minx = 9999; r_maxx = -1; r_order_err = 0; r_post_busy = 0;
    r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1; r_fc = '0; r_lc = '0;
    seen = 1'b0; tail = 0;
    for (int i = 0; i < 25000 && tail < 5; i++) begin
      start = 1'b0;
      if (seen) begin
        tail++;
        if (busy) r_post_busy++;
      end else if (busy) begin
        r_busy++;
      end
      if (writeEn) begin
        if (v.raster && (int'(x_out) != r_writes % 160 || int'(y_out) != r_writes / 160))
          r_order_err++;
        if (r_writes == 0) begin r_fx = int'(x_out); r_fy = int'(y_out); r_fc = colour; end
        r_lx = int'(x_out); r_ly = int'(y_out); r_lc = colour;
        if (int'(x_out) < r_minx) r_minx = int'(x_out);
        if (int'(x_out) > r_maxx) r_maxx = int'(x_out);
        if (int'(x_out) >= v.rx_lo && int'(x_out) <= v.rx_hi) r_inrange++;
        r_writes++;
      end
      if (done) begin
        r_done++;
        if (busy || writeEn) r_done_bad++;
        if (!seen && v.fin_start) begin cmd = 2'd0; start = 1'b1; end
        seen = 1'b1;
      end
      if (i == v.inj_at) begin start = 1'b1; x = 8'd60; cmd = 2'd0; end
      @(negedge clk);
    end
    start = 1'b0;
    r_timeout = !seen;
  endtask

  initial begin
    logic [GB-1:0] g_tl, g_s1, g_ones, g_zero;
    int            w, d;
    g_zero = '0;
    g_ones = '1;
    g_tl   = g_zero; g_tl[431] = 1'b1;
    g_s1   = g_zero; g_s1[260] = 1'b1;

    vecs[0] = '{2'd0, 8'd10, 7'd20, g_tl, 3'b111, 1'b0, 3'b010, 3'b000, -1, 1'b0, 1, 0, 1'b0,
                1, 432, 10, 20, 3'b010, 10, 20, 3'b010, 10, 10};
    vecs[1] = '{2'd0, 8'd10, 7'd20, g_zero, 3'b101, 1'b1, 3'b111, 3'b000, -1, 1'b0, 22, 33, 1'b0,
                288, 432, 10, 20, 3'b000, 45, 31, 3'b000, 10, 45};
    vecs[2] = '{2'd0, 8'd150, 7'd115, g_ones, 3'b111, 1'b0, 3'b111, 3'b000, -1, 1'b0, 0, 149, 1'b0,
                50, 432, 150, 115, 3'b111, 159, 119, 3'b111, 150, 159};
    vecs[3] = '{2'd2, 8'd0, 7'd0, g_zero, 3'b000, 1'b0, 3'b000, 3'b001, -1, 1'b0, 1, 0, 1'b1,
                19200, 19200, 0, 0, 3'b001, 159, 119, 3'b001, 0, 159};
    vecs[4] = '{2'd1, 8'd100, 7'd50, g_ones, 3'b000, 1'b0, 3'b111, 3'b011, -1, 1'b0, 1, 0, 1'b0,
                432, 432, 100, 50, 3'b011, 135, 61, 3'b011, 100, 135};
    vecs[5] = '{2'd3, 8'd5, 7'd5, g_ones, 3'b111, 1'b1, 3'b111, 3'b111, -1, 1'b0, 0, 159, 1'b0,
                0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0};
    vecs[6] = '{2'd0, 8'd0, 7'd0, g_s1, 3'b111, 1'b0, 3'b101, 3'b000, -1, 1'b0, 1, 0, 1'b0,
                1, 432, 15, 2, 3'b101, 15, 2, 3'b101, 15, 15};
    vecs[7] = '{2'd1, 8'd140, 7'd110, g_zero, 3'b111, 1'b0, 3'b000, 3'b110, -1, 1'b0, 0, 139, 1'b0,
                200, 432, 140, 110, 3'b110, 159, 119, 3'b110, 140, 159};
    vecs[8] = '{2'd1, 8'd20, 7'd30, g_ones, 3'b111, 1'b0, 3'b000, 3'b010, 10, 1'b0, 56, 159, 1'b0,
                432, 432, 20, 30, 3'b010, 55, 41, 3'b010, 20, 55};
    vecs[9] = vecs[0];
    vecs[9].fin_start = 1'b1;

    // Reset values
    clear = 1'b1; start = 1'b0; cmd = '0; x = '0; y = '0; glyphs = '0;
    slot_en = '0; opaque = 1'b0; fg = '0; bg = '0;
    repeat (3) @(negedge clk);
    check("rst_writeEn", writeEn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_colour", colour, 0);
    check("rst_state", state_dbg, 0);
    clear = 1'b0;

    // Abort a DRAW at cycle 50 with a reset
    @(negedge clk);
    cmd = 2'd0; x = 8'd10; y = 7'd20; glyphs = g_zero; slot_en = 3'b111;
    opaque = 1'b1; fg = 3'b111; bg = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before", busy, 1);
    check("abort_we_before", writeEn, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_writeEn", writeEn, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", state_dbg, 0);
    w = 0; d = 0;
    for (int i = 0; i < 500; i++) begin
      if (writeEn) w++;
      if (done) d++;
      @(negedge clk);
    end
    check("abort_later_writes", w, 0);
    check("abort_later_done", d, 0);

    for (int k = 0; k < 10; k++) begin
      run_vec(vecs[k]);
      check($sformatf("v%0d_timeout", k), r_timeout, 0);
      check($sformatf("v%0d_writes", k), r_writes, vecs[k].exp_writes);
      check($sformatf("v%0d_busy_cycles", k), r_busy, vecs[k].exp_busy);
      check($sformatf("v%0d_done_pulses", k), r_done, 1);
      check($sformatf("v%0d_done_with_busy_or_we", k), r_done_bad, 0);
      check($sformatf("v%0d_busy_after_done", k), r_post_busy, 0);
      check($sformatf("v%0d_writes_in_forbidden_x", k), r_inrange, 0);
      if (vecs[k].exp_writes > 0) begin
        check($sformatf("v%0d_first_x", k), r_fx, vecs[k].exp_fx);
        check($sformatf("v%0d_first_y", k), r_fy, vecs[k].exp_fy);
        check($sformatf("v%0d_first_colour", k), r_fc, vecs[k].exp_fc);
        check($sformatf("v%0d_last_x", k), r_lx, vecs[k].exp_lx);
        check($sformatf("v%0d_last_y", k), r_ly, vecs[k].exp_ly);
        check($sformatf("v%0d_last_colour", k), r_lc, vecs[k].exp_lc);
        check($sformatf("v%0d_min_x", k), r_minx, vecs[k].exp_minx);
        check($sformatf("v%0d_max_x", k), r_maxx, vecs[k].exp_maxx);
      end
      if (vecs[k].raster) check($sformatf("v%0d_raster_order", k), r_order_err, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
